// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, step codes and helpers for the iterative AES-128 core
// Holds the round count, sub-step limits and the 3-bit step code shared with
// the key-expansion unit (ST_ARK=1 selects key expansion/AddRoundKey there).
package aes_pkg;

    localparam int NR           = 10;
    localparam int SB_CYCLES    = 16;
    localparam int MC_CYCLES    = 4;
    localparam int ARK_LAST_CNT = 6;
    localparam logic [3:0] CNT_ROUND0 = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARK  = 3'd1,
        ST_SB   = 3'd2,
        ST_SR   = 3'd3,
        ST_MC   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Last cnt value of each step; round 0 AddRoundKey sits at CNT_ROUND0 for one cycle
    function automatic logic [3:0] step_limit(input state_t s, input logic round0);
        return (s == ST_ARK) ? (round0 ? CNT_ROUND0 : 4'(ARK_LAST_CNT)) :
               (s == ST_SB)  ? 4'(SB_CYCLES - 1) :
               (s == ST_MC)  ? 4'(MC_CYCLES - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/aes_step_counter.sv
// aes_step_counter: 4-bit sub-step counter with load, clear, enable and terminal flag
// Ports: clk, rst_n (async, active-low); load (cnt<=CNT_ROUND0, highest priority),
// clear (cnt<=0), en (increment); limit in; cnt out; term = (cnt == limit).
module aes_step_counter
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  logic       en,
    input  logic [3:0] limit,
    output logic [3:0] cnt,
    output logic       term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= 4'd0;
        else if (load)  cnt <= CNT_ROUND0;
        else if (clear) cnt <= 4'd0;
        else if (en)    cnt <= cnt + 4'd1;
    end

    assign term = cnt == limit;

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencing FSM for the iterative AES-128 core
// Ports: clk, rst_n (async, active-low); start/inv_req request handshake (ready high in IDLE);
// abort synchronous cancel; busy, done pulse; current_state, round, cnt, inv_en,
// key_init and ark_en drive the key-expansion and round datapath (all registered).
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv_req,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] current_state,
    output logic [3:0] round,
    output logic [3:0] cnt,
    output logic       inv_en,
    output logic       key_init,
    output logic       ark_en
);

    state_t     state, state_d;
    logic [3:0] round_d, limit;
    logic       inv_d, term, last, cnt_load, cnt_clear, cnt_en;

    assign last  = round == 4'(NR);
    assign limit = step_limit(state, round == 4'd0);

    aes_step_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .clear (cnt_clear),
        .en    (cnt_en),
        .limit (limit),
        .cnt   (cnt),
        .term  (term)
    );

    always_comb begin
        state_d   = state;
        round_d   = round;
        inv_d     = inv_en;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        if (state == ST_IDLE) begin
            cnt_clear = 1'b1;
            round_d   = 4'd0;
            if (start) begin
                state_d  = ST_ARK;
                inv_d    = inv_req;
                cnt_load = 1'b1;
            end
        end else if (abort || state == ST_DONE) begin
            state_d   = ST_IDLE;
            round_d   = 4'd0;
            cnt_clear = 1'b1;
        end else if (!term) begin
            cnt_en = 1'b1;
        end else begin
            cnt_clear = 1'b1;
            case (state)
                // Encrypt rounds end at ARK; decrypt rounds end at MC except the final one
                ST_ARK: begin
                    if (last) begin
                        state_d   = ST_DONE;
                        cnt_clear = 1'b0;
                    end else if (inv_en && round != 4'd0) begin
                        state_d = ST_MC;
                    end else begin
                        state_d = inv_en ? ST_SR : ST_SB;
                        round_d = round + 4'd1;
                    end
                end
                ST_SB:   state_d = inv_en ? ST_ARK : ST_SR;
                ST_SR:   state_d = inv_en ? ST_SB : (last ? ST_ARK : ST_MC);
                ST_MC: begin
                    state_d = inv_en ? ST_SR : ST_ARK;
                    round_d = inv_en ? round + 4'd1 : round;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Strobes are registered alongside the state they belong to; ark_en for rounds >=1
    // lands on ARK cnt 6, i.e. the cycle after ARK cnt 5 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            round    <= 4'd0;
            inv_en   <= 1'b0;
            done     <= 1'b0;
            key_init <= 1'b0;
            ark_en   <= 1'b0;
        end else begin
            state    <= state_d;
            round    <= round_d;
            inv_en   <= inv_d;
            done     <= state_d == ST_DONE;
            key_init <= state_d == ST_ARK && round_d == 4'd0;
            ark_en   <= state_d == ST_ARK &&
                        (round_d == 4'd0 || (cnt_en && cnt == 4'(ARK_LAST_CNT - 1)));
        end
    end

    assign current_state = state;
    assign ready         = state == ST_IDLE;
    assign busy          = state != ST_IDLE && state != ST_DONE;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: cycle-by-cycle check of aes_round_ctrl against a trace-table model
module tb_aes_round_ctrl;

    localparam int S_IDLE = 0, S_ARK = 1, S_SB = 2, S_SR = 3, S_MC = 4, S_DONE = 5;
    localparam int LAST = 278;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start, inv_req, abort;
    logic ready, busy, done, inv_en, key_init, ark_en;
    logic [2:0] current_state;
    logic [3:0] round, cnt;

    int errors = 0;
    int checks = 0;

    int tr_st [0:299];
    int tr_r  [0:299];
    int tr_c  [0:299];
    bit tr_ki [0:299];
    bit tr_ark[0:299];
    int tr_len = 0;
    int pos = 0;
    bit m_inv = 1'b0;

    logic [16:0] dut_vec;
    assign dut_vec = {ready, busy, done, current_state, round, cnt, inv_en, key_init, ark_en};

    aes_round_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .inv_req       (inv_req),
        .abort         (abort),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .current_state (current_state),
        .round         (round),
        .cnt           (cnt),
        .inv_en        (inv_en),
        .key_init      (key_init),
        .ark_en        (ark_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t pos=%0d)", name, act, exp, $time, pos);
        end
    endtask

    task automatic put(inout int n, input int st, input int r, input int c, input bit ki, input bit ark);
        if (n < 300) begin
            tr_st[n] = st; tr_r[n] = r; tr_c[n] = c; tr_ki[n] = ki; tr_ark[n] = ark;
        end
        n++;
    endtask

    task automatic seg(inout int n, input int st, input int r, input int len);
        for (int c = 0; c < len; c++) put(n, st, r, c, 1'b0, st == S_ARK && c == 6);
    endtask

    // Expected per-cycle trace, indexed by cycles since the acceptance edge
    task automatic build(input bit inv);
        int n;
        n = 1;
        put(n, S_ARK, 0, 15, 1'b1, 1'b1);
        for (int r = 1; r <= 10; r++) begin
            if (!inv) begin
                seg(n, S_SB, r, 16); seg(n, S_SR, r, 1);
                if (r < 10) seg(n, S_MC, r, 4);
                seg(n, S_ARK, r, 7);
            end else begin
                seg(n, S_SR, r, 1); seg(n, S_SB, r, 16); seg(n, S_ARK, r, 7);
                if (r < 10) seg(n, S_MC, r, 4);
            end
        end
        put(n, S_DONE, 10, 6, 1'b0, 1'b0);
        tr_len = n - 1;
    endtask

    function automatic logic [16:0] exp_vec();
        return {pos == 0, pos >= 1 && pos < LAST, pos == LAST, 3'(tr_st[pos]),
                4'(tr_r[pos]), 4'(tr_c[pos]), m_inv, tr_ki[pos], tr_ark[pos]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0;
            m_inv = 1'b0;
        end else if (pos == 0) begin
            if (start) begin
                m_inv = inv_req;
                build(inv_req);
                pos = 1;
            end
        end else if (abort || pos == LAST) begin
            pos = 0;
        end else begin
            pos++;
        end
    end

    always @(negedge clk) check("cycle", dut_vec, exp_vec());

    task automatic run_block(input bit inv, input string name);
        int k;
        @(negedge clk); start = 1'b1; inv_req = inv;
        @(negedge clk); start = 1'b0;
        k = 1;
        while (!done && k < 400) begin @(negedge clk); k++; end
        check(name, k, LAST);
    endtask

    task automatic quiet(input string name, input int cycles);
        int d;
        d = 0;
        repeat (cycles) begin @(negedge clk); if (done) d++; end
        check(name, d, 0);
    endtask

    initial begin
        int k;
        start = 1'b0; inv_req = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vec", dut_vec, 17'h10000);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_hold", dut_vec, 17'h10000);

        run_block(1'b0, "enc_latency");
        check("model_len", tr_len, LAST);
        check("enc_r0", {tr_st[1], tr_c[1]}, {32'd1, 32'd15});
        check("enc_sb1", {tr_st[2], tr_r[2]}, {32'd2, 32'd1});
        check("enc_sr1", tr_st[18], S_SR);
        check("enc_mc1", tr_st[19], S_MC);
        check("enc_ark1", tr_st[23], S_ARK);
        check("enc_ark_en", {tr_ark[28], tr_ark[29]}, 2'b01);
        check("enc_r10_nomc", {tr_st[270], tr_st[271]}, {32'd3, 32'd1});
        check("enc_last", {tr_st[277], tr_r[277], tr_c[277]}, {32'd1, 32'd10, 32'd6});

        run_block(1'b1, "dec_latency");
        check("dec_inv_en", inv_en, 1);
        check("dec_order", {tr_st[2], tr_st[3], tr_st[19], tr_st[26]}, {32'd3, 32'd2, 32'd1, 32'd4});
        check("dec_r2", {tr_st[30], tr_r[30]}, {32'd3, 32'd2});
        check("dec_r10_end", {tr_st[276], tr_st[277]}, {32'd1, 32'd1});

        @(negedge clk); start = 1'b1; inv_req = 1'b0;
        @(negedge clk); start = 1'b0;
        k = 1;
        while (round != 4'd3 && k < 400) begin @(negedge clk); k++; end
        start = 1'b1; inv_req = 1'b1;
        @(negedge clk); k++; start = 1'b0;
        while (!done && k < 400) begin @(negedge clk); k++; end
        check("busy_start_latency", k, LAST);
        quiet("busy_start_not_queued", 300);

        run_block(1'b0, "pre_done_start");
        start = 1'b1;
        @(negedge clk);
        @(negedge clk); start = 1'b0;
        k = 1;
        while (!done && k < 400) begin @(negedge clk); k++; end
        check("done_cycle_start_latency", k, LAST);

        @(negedge clk); start = 1'b1; inv_req = 1'b0;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(current_state == 3'd2 && round == 4'd5 && cnt == 4'd7) && k < 400) begin
            @(negedge clk); k++;
        end
        check("reach_r5_sb7", {current_state, round, cnt}, {3'd2, 4'd5, 4'd7});
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_idle", {ready, done, round, cnt}, 10'h200);
        quiet("abort_no_done", 300);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(current_state == 3'd1 && round == 4'd9 && cnt == 4'd5) && k < 400) begin
            @(negedge clk); k++;
        end
        check("reach_r9_ark5", {current_state, round, cnt}, {3'd1, 4'd9, 4'd5});
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_vec, 17'h10000);
        @(negedge clk); rst_n = 1'b1;
        run_block(1'b1, "post_reset_latency");

        repeat (4000) begin
            @(negedge clk);
            start   = $urandom_range(0, 19) == 0;
            inv_req = 1'($urandom_range(0, 1));
            abort   = $urandom_range(0, 399) == 0;
        end
        start = 1'b0; abort = 1'b0;
        repeat (300) @(negedge clk);
        check("final_idle", {ready, busy}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
